fifth_circuit_comparator: RTL and testbench

- Registered unsigned magnitude comparator for two 3-bit operands, A and B.
- Exactly one of three flags is set: A>B, A==B or A<B.
- Sits as a leaf compute block.
- The testbench sweeps all 64 input combinations, each held for 10 time units. The block must give the correct flags for every one of the 64.

---
 rtl/fifth_circuit_comparator.sv | 100 ++++++++++
 tb/tb_fifth_circuit_comparator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifth_circuit_comparator.sv
// Registered magnitude comparator: A={a0,a1,a2}, B={b0,b1,b2} (a0/b0 are MSBs).
// Exactly one of gt/eq/lt is set for each captured result, one cycle after in_valid.
module fifth_circuit_comparator #(
    parameter int WIDTH  = 3,
    parameter bit SIGNED = 1'b0
) (
    output logic gt,
    output logic eq,
    output logic lt,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid
);

    localparam int PINS = 3;

    logic [PINS-1:0]  a_pins;
    logic [PINS-1:0]  b_pins;
    logic [WIDTH-1:0] a_vec;
    logic [WIDTH-1:0] b_vec;
    logic [WIDTH-1:0] e_bit;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] l_bit;
    logic [WIDTH-1:0] gt_term;
    logic [WIDTH-1:0] lt_term;
    logic [WIDTH:0]   eq_chain;

    logic gt_next, eq_next, lt_next;
    logic gt_reg, eq_reg, lt_reg, out_valid_reg;

    assign a_pins = {a0, a1, a2};
    assign b_pins = {b0, b1, b2};

    // Operands wider than the pins are extended (sign-extended when signed).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pack
            if (gi < PINS) begin : g_pin
                assign a_vec[gi] = a_pins[gi];
                assign b_vec[gi] = b_pins[gi];
            end else begin : g_ext
                assign a_vec[gi] = SIGNED ? a_pins[PINS-1] : 1'b0;
                assign b_vec[gi] = SIGNED ? b_pins[PINS-1] : 1'b0;
            end
        end
    endgenerate

    // MSB-first cascade: a bit decides only if every more significant bit matched.
    assign eq_chain[WIDTH] = 1'b1;
    generate
        for (genvar gi = WIDTH - 1; gi >= 0; gi--) begin : g_cascade
            assign e_bit[gi] = ~(a_vec[gi] ^ b_vec[gi]);
            if (SIGNED && (gi == WIDTH - 1)) begin : g_sign
                // A set sign bit means the operand is the smaller one.
                assign g_bit[gi] = ~a_vec[gi] & b_vec[gi];
                assign l_bit[gi] = a_vec[gi] & ~b_vec[gi];
            end else begin : g_mag
                assign g_bit[gi] = a_vec[gi] & ~b_vec[gi];
                assign l_bit[gi] = ~a_vec[gi] & b_vec[gi];
            end
            assign eq_chain[gi] = eq_chain[gi+1] & e_bit[gi];
            assign gt_term[gi]  = eq_chain[gi+1] & g_bit[gi];
            assign lt_term[gi]  = eq_chain[gi+1] & l_bit[gi];
        end
    endgenerate

    always_comb begin
        gt_next = |gt_term;
        lt_next = |lt_term;
        eq_next = eq_chain[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            lt_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (in_valid) begin
                gt_reg <= gt_next;
                eq_reg <= eq_next;
                lt_reg <= lt_next;
            end
            out_valid_reg <= in_valid;
        end
    end

    assign gt        = gt_reg;
    assign eq        = eq_reg;
    assign lt        = lt_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fifth_circuit_comparator.sv
// Directed bench for fifth_circuit_comparator: reset, full 64-vector sweep,
// boundary operands, hold, mid-stream reset and a signed build alongside.
module tb_fifth_circuit_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
    logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;

    logic gt_u, eq_u, lt_u, ov_u;
    logic gt_s, eq_s, lt_s, ov_s;

    int checks = 0;
    int errors = 0;
    int n_gt = 0, n_eq = 0, n_lt = 0;

    always #5 clk = ~clk;

    fifth_circuit_comparator dut (
        .gt(gt_u), .eq(eq_u), .lt(lt_u),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(ov_u)
    );

    fifth_circuit_comparator #(.WIDTH(3), .SIGNED(1'b1)) dut_s (
        .gt(gt_s), .eq(eq_s), .lt(lt_s),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(ov_s)
    );

    // Compares {gt,eq,lt,out_valid}.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed gt/eq/lt/ov=%b expected %b", tag, obs, exp);
        end
        $display("check %-14s observed %b expected %b", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic v);
        @(negedge clk);
        {a0, a1, a2} = a;
        {b0, b1, b2} = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_u(input logic [2:0] a, input logic [2:0] b);
        int ia = a;
        int ib = b;
        return {ia > ib, ia == ib, ia < ib, 1'b1};
    endfunction

    function automatic logic [3:0] ref_s(input logic [2:0] a, input logic [2:0] b);
        int ia = a[2] ? int'(a) - 8 : int'(a);
        int ib = b[2] ? int'(b) - 8 : int'(b);
        return {ia > ib, ia == ib, ia < ib, 1'b1};
    endfunction

    initial begin
        logic [2:0] av, bv;

        // Reset held across edges keeps everything clear.
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {gt_u, eq_u, lt_u, ov_u}, 4'b0000);
        @(negedge clk) rst = 1'b0;

        drive(3'd5, 3'd5, 1'b1);
        check("first_eq", {gt_u, eq_u, lt_u, ov_u}, 4'b0101);

        // Asynchronous reset between edges clears at once.
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_rst", {gt_u, eq_u, lt_u, ov_u}, 4'b0000);
        #1 rst = 1'b0;

        drive(3'd5, 3'd5, 1'b1);
        check("post_rst_eq", {gt_u, eq_u, lt_u, ov_u}, 4'b0101);

        // Exhaustive sweep with a mid-stream reset pulse at vector 32.
        for (int i = 0; i < 64; i++) begin
            av = 3'(i >> 3);
            bv = 3'(i);
            drive(av, bv, 1'b1);
            check($sformatf("sweep_u_%0d", i), {gt_u, eq_u, lt_u, ov_u}, ref_u(av, bv));
            check($sformatf("sweep_s_%0d", i), {gt_s, eq_s, lt_s, ov_s}, ref_s(av, bv));
            if (ov_u) begin
                n_gt += int'(gt_u);
                n_eq += int'(eq_u);
                n_lt += int'(lt_u);
            end
            if (i == 32) begin
                @(negedge clk);
                #1 rst = 1'b1;
                #1 check("mid_rst", {gt_u, eq_u, lt_u, ov_u}, 4'b0000);
                #2 rst = 1'b0;
                drive(3'd1, 3'd1, 1'b1);
                check("mid_rst_eq", {gt_u, eq_u, lt_u, ov_u}, 4'b0101);
            end
        end
        checks++;
        assert (n_gt == 28 && n_eq == 8 && n_lt == 28) else begin
            errors++;
            $error("FAIL sweep_counts observed gt=%0d eq=%0d lt=%0d expected 28/8/28", n_gt, n_eq, n_lt);
        end
        $display("check sweep_counts observed gt=%0d eq=%0d lt=%0d expected 28/8/28", n_gt, n_eq, n_lt);

        // Boundary operands.
        drive(3'd7, 3'd0, 1'b1); check("a7_b0", {gt_u, eq_u, lt_u, ov_u}, 4'b1001);
        drive(3'd0, 3'd7, 1'b1); check("a0_b7", {gt_u, eq_u, lt_u, ov_u}, 4'b0011);
        drive(3'd4, 3'd3, 1'b1); check("a4_b3", {gt_u, eq_u, lt_u, ov_u}, 4'b1001);
        drive(3'd6, 3'd7, 1'b1); check("a6_b7", {gt_u, eq_u, lt_u, ov_u}, 4'b0011);
        drive(3'd3, 3'd2, 1'b1); check("a3_b2", {gt_u, eq_u, lt_u, ov_u}, 4'b1001);
        drive(3'd7, 3'd7, 1'b1); check("a7_b7", {gt_u, eq_u, lt_u, ov_u}, 4'b0101);
        drive(3'd0, 3'd0, 1'b1); check("a0_b0", {gt_u, eq_u, lt_u, ov_u}, 4'b0101);

        // Hold: flags keep the last capture while in_valid is low.
        drive(3'd2, 3'd6, 1'b1); check("hold_cap", {gt_u, eq_u, lt_u, ov_u}, 4'b0011);
        drive(3'd7, 3'd1, 1'b0); check("hold_keep", {gt_u, eq_u, lt_u, ov_u}, 4'b0010);
        drive(3'd7, 3'd1, 1'b1); check("hold_release", {gt_u, eq_u, lt_u, ov_u}, 4'b1001);

        // Signed build.
        drive(3'b100, 3'b011, 1'b1); check("s_m4_p3", {gt_s, eq_s, lt_s, ov_s}, 4'b0011);
        drive(3'b111, 3'b110, 1'b1); check("s_m1_m2", {gt_s, eq_s, lt_s, ov_s}, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
